// File: rtl/agc_peak_error_detector_if.sv
// Sample/threshold input bundle and window-result outputs of the AGC peak error detector.
interface agc_peak_error_detector_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CNT_W  = 16
);
    logic                     i_valid;
    logic signed [DATA_W-1:0] i_sample;
    logic        [31:0]       i_thresh;
    logic        [31:0]       o_data;
    logic                     o_strobe;
    logic        [DATA_W-1:0] o_peak;
    logic        [CNT_W-1:0]  o_win_cnt;

    // Upstream side: supplies samples and threshold, observes results.
    modport master (
        output i_valid, i_sample, i_thresh,
        input  o_data, o_strobe, o_peak, o_win_cnt
    );

    // Detector side.
    modport slave (
        input  i_valid, i_sample, i_thresh,
        output o_data, o_strobe, o_peak, o_win_cnt
    );
endinterface

// File: rtl/agc_peak_error_detector.sv
// Windowed absolute-peak tracker; emits a one-cycle excess-over-threshold term per window.
module agc_peak_error_detector #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned WIN_LEN = 64,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                   clk_8,
    input  logic                   rst,
    agc_peak_error_detector_if.slave bus
);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIN_LEN - 1);

    typedef enum logic {
        COLLECT = 1'b0,
        EMIT    = 1'b1
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] run_peak;
    logic [DATA_W-1:0] peak_q;
    logic [31:0]       data_q;
    logic              strobe_q;
    logic [CNT_W-1:0]  cnt_q;

    logic [DATA_W-1:0] raw_c;
    logic [DATA_W-1:0] mag_c;
    logic [DATA_W-1:0] final_c;
    logic [31:0]       excess_c;

    // Magnitude of the sample; the most negative code maps to 2^(DATA_W-1) unsigned.
    always_comb begin
        raw_c    = bus.i_sample;
        mag_c    = raw_c[DATA_W-1] ? (~raw_c + DATA_W'(1)) : raw_c;
        final_c  = (mag_c > run_peak) ? mag_c : run_peak;
        excess_c = (32'(final_c) > bus.i_thresh) ? (32'(final_c) - bus.i_thresh) : 32'd0;
    end

    // Window FSM: accumulate peak in COLLECT, one-cycle result pulse in EMIT.
    always_ff @(posedge clk_8 or negedge rst) begin
        if (!rst) begin
            state    <= COLLECT;
            run_peak <= '0;
            peak_q   <= '0;
            data_q   <= '0;
            strobe_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            strobe_q <= 1'b0;
            data_q   <= '0;
            case (state)
                COLLECT: begin
                    if (bus.i_valid) begin
                        if (cnt_q == LAST_IDX) begin
                            peak_q   <= final_c;
                            data_q   <= excess_c;
                            strobe_q <= 1'b1;
                            run_peak <= '0;
                            cnt_q    <= '0;
                            state    <= EMIT;
                        end else begin
                            run_peak <= final_c;
                            cnt_q    <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                EMIT: begin
                    // A sample arriving during the pulse opens the next window.
                    if (bus.i_valid) begin
                        run_peak <= mag_c;
                        cnt_q    <= CNT_W'(1);
                    end
                    state <= COLLECT;
                end
                default: state <= COLLECT;
            endcase
        end
    end

    assign bus.o_data    = data_q;
    assign bus.o_strobe  = strobe_q;
    assign bus.o_peak    = peak_q;
    assign bus.o_win_cnt = cnt_q;
endmodule

// File: tb/tb_agc_peak_error_detector.sv
// Randomized + directed bench for agc_peak_error_detector against a queue-based window model.
module tb_agc_peak_error_detector;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned WIN_LEN = 4;
    localparam int unsigned CNT_W   = 4;

    logic clk_8 = 1'b0;
    logic rst;

    agc_peak_error_detector_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    agc_peak_error_detector #(
        .DATA_W (DATA_W),
        .WIN_LEN(WIN_LEN),
        .CNT_W  (CNT_W)
    ) dut (
        .clk_8(clk_8),
        .rst  (rst),
        .bus  (bus)
    );

    always #5 clk_8 = ~clk_8;

    int  checks   = 0;
    int  failures = 0;
    bit  chk_en   = 1'b0;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: window = list of magnitudes; result when list reaches WIN_LEN.
    longint win[$];
    longint exp_data, exp_peak, exp_cnt;
    bit     exp_strobe;

    always @(negedge rst) begin
        win.delete();
        exp_data = 0; exp_peak = 0; exp_cnt = 0; exp_strobe = 0;
    end

    always @(posedge clk_8) begin
        longint sv, fin;
        if (rst === 1'b1) begin
            exp_strobe = 0;
            exp_data   = 0;
            if (bus.i_valid) begin
                sv = longint'(bus.i_sample);
                win.push_back(sv < 0 ? -sv : sv);
                if (win.size() == WIN_LEN) begin
                    fin = 0;
                    foreach (win[k]) if (win[k] > fin) fin = win[k];
                    exp_peak   = fin;
                    exp_data   = (fin > longint'(bus.i_thresh)) ? fin - longint'(bus.i_thresh) : 0;
                    exp_strobe = 1;
                    win.delete();
                end
            end
            exp_cnt = win.size();
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    bit prev_nz = 1'b0;
    always @(negedge clk_8) begin
        if (chk_en) begin
            check("o_data",    64'(bus.o_data),    64'(exp_data));
            check("o_strobe",  64'(bus.o_strobe),  64'(exp_strobe));
            check("o_peak",    64'(bus.o_peak),    64'(exp_peak));
            check("o_win_cnt", 64'(bus.o_win_cnt), 64'(exp_cnt));
            check("data_single_cycle", 64'(prev_nz && (bus.o_data != 0)), 64'(0));
            prev_nz = (bus.o_data != 0);
        end
    end

    task automatic drive(input bit v, input int s);
        @(negedge clk_8);
        bus.i_valid  = v;
        bus.i_sample = 16'(s);
    endtask

    int s4[12];
    int g[4];

    initial begin
        rst          = 1'b1;
        bus.i_valid  = 1'b0;
        bus.i_sample = '0;
        bus.i_thresh = 32'd0;
        #2 rst = 1'b0;
        #1;
        chk_en = 1'b1;
        repeat (2) @(negedge clk_8);
        check("reset_data",   64'(bus.o_data),    64'd0);
        check("reset_strobe", 64'(bus.o_strobe),  64'd0);
        check("reset_peak",   64'(bus.o_peak),    64'd0);
        check("reset_cnt",    64'(bus.o_win_cnt), 64'd0);
        @(negedge clk_8);
        rst = 1'b1;

        // Basic window: 10,-250,30,40 thr 100
        bus.i_thresh = 32'd100;
        drive(1, 10); drive(1, -250); drive(1, 30); drive(1, 40);
        drive(0, 0);
        check("t1_strobe", 64'(bus.o_strobe), 64'd1);
        check("t1_data",   64'(bus.o_data),   64'd150);
        check("t1_peak",   64'(bus.o_peak),   64'd250);
        drive(0, 0);
        check("t1_data_next",   64'(bus.o_data),   64'd0);
        check("t1_strobe_next", 64'(bus.o_strobe), 64'd0);
        check("t1_peak_held",   64'(bus.o_peak),   64'd250);

        // Peak at threshold -> zero excess but strobe still pulses
        bus.i_thresh = 32'd500;
        drive(1, 400); drive(1, -500); drive(1, 0); drive(1, 12);
        drive(0, 0);
        check("t2_strobe", 64'(bus.o_strobe), 64'd1);
        check("t2_data",   64'(bus.o_data),   64'd0);
        check("t2_peak",   64'(bus.o_peak),   64'd500);

        // Most negative sample, threshold 0
        bus.i_thresh = 32'd0;
        drive(1, -32768); drive(1, 1); drive(1, 2); drive(1, 3);
        drive(0, 0);
        check("t3_data", 64'(bus.o_data), 64'd32768);
        check("t3_peak", 64'(bus.o_peak), 64'd32768);

        // Continuous valid across 3 windows; sample in first strobe cycle is -7000
        bus.i_thresh = 32'd1000;
        for (int i = 0; i < 12; i++) s4[i] = int'($urandom_range(0, 198)) - 99;
        s4[4] = -7000;
        for (int i = 0; i <= 12; i++) begin
            if (i < 12) drive(1, s4[i]);
            else        drive(0, 0);
            check("t4_strobe_spacing", 64'(bus.o_strobe), 64'((i == 4) || (i == 8) || (i == 12)));
            if (i == 8) check("t4_carry_sample", 64'(bus.o_data), 64'd6000);
        end

        // Gapped valid, threshold changes mid-window 0 -> 50
        bus.i_thresh = 32'd0;
        g[0] = 70; g[1] = -20; g[2] = 30; g[3] = 10;
        for (int j = 0; j < 4; j++) begin
            drive(1, g[j]);
            if (j == 2) bus.i_thresh = 32'd50;
            drive(0, 0);
            if (j == 3) begin
                check("t5_strobe", 64'(bus.o_strobe), 64'd1);
                check("t5_data",   64'(bus.o_data),   64'd20);
                check("t5_peak",   64'(bus.o_peak),   64'd70);
            end else begin
                drive(0, 0);
                check("t5_cnt_gap", 64'(bus.o_win_cnt), 64'(j + 1));
            end
        end

        // Reset mid-window discards the partial peak
        bus.i_thresh = 32'd0;
        drive(1, 900); drive(1, -3);
        drive(0, 0);
        check("t6_cnt_before", 64'(bus.o_win_cnt), 64'd2);
        #2 rst = 1'b0;
        #1;
        check("t6_cnt_reset",  64'(bus.o_win_cnt), 64'd0);
        check("t6_peak_reset", 64'(bus.o_peak),    64'd0);
        repeat (2) @(negedge clk_8);
        rst = 1'b1;
        drive(1, 5); drive(1, 5); drive(1, 5); drive(1, 5);
        drive(0, 0);
        check("t6_strobe", 64'(bus.o_strobe), 64'd1);
        check("t6_peak",   64'(bus.o_peak),   64'd5);
        check("t6_data",   64'(bus.o_data),   64'd5);

        // Randomized traffic with occasional resets and extreme thresholds/samples
        for (int n = 0; n < 1500; n++) begin
            int sel, smp;
            sel = int'($urandom_range(0, 9));
            case (sel)
                0:       smp = -32768;
                1:       smp = 32767;
                default: smp = int'($urandom_range(0, 65535)) - 32768;
            endcase
            drive(($urandom_range(0, 9) < 7), smp);
            case ($urandom_range(0, 3))
                0:       bus.i_thresh = 32'd0;
                1:       bus.i_thresh = 32'($urandom_range(0, 40000));
                2:       bus.i_thresh = 32'd65536 + 32'($urandom_range(0, 1000));
                default: bus.i_thresh = 32'hFFFF_FFFF;
            endcase
            if ($urandom_range(0, 199) == 0) begin
                #2 rst = 1'b0;
                @(negedge clk_8);
                rst = 1'b1;
            end
        end

        drive(0, 0);
        drive(0, 0);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
